sram_pattern_test: RTL and testbench

SRAM_PATTERN_TEST -- requirements
Module: sram_pattern_test

---
 rtl/sram_test_pkg.sv | 28 ++
 rtl/sram_pattern_gen.sv | 31 +++
 rtl/sram_pattern_test.sv | 233 +++++++++++++++++++++++
 tb/tb_sram_pattern_test.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_test_pkg.sv
// sram_test_pkg: shared definitions for the SRAM pattern tester.
//   state_t      - controller FSM states
//   mode_t       - pattern select encodings (ADDR, CHECKER, WALK, ALL)
//   CHK_EVEN/ODD - checkerboard words, sliced to DATA_W by the generator
//   ERR_CNT_W    - width of the mismatch counter
package sram_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_COMPARE,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_ADDR    = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_WALK    = 2'd2,
    MODE_ALL     = 2'd3
  } mode_t;

  localparam logic [31:0] CHK_EVEN = 32'h5555_5555;
  localparam logic [31:0] CHK_ODD  = 32'hAAAA_AAAA;

  localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/sram_pattern_gen.sv
// sram_pattern_gen: combinational test-data generator.
//   pattern - ADDR / CHECKER / WALK (ALL is never presented here)
//   pass    - 0: true pattern, 1: bitwise inverse
//   addr    - low DATA_W bits of the current SRAM address
//   data    - expected / write data word
module sram_pattern_gen
  import sram_test_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  mode_t             pattern,
  input  logic              pass,
  input  logic [DATA_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam int IDX_W = $clog2(DATA_W);

  logic [DATA_W-1:0] w_base;

  always_comb begin
    w_base = '0;
    case (pattern)
      MODE_CHECKER: w_base = addr[0] ? CHK_ODD[DATA_W-1:0] : CHK_EVEN[DATA_W-1:0];
      MODE_WALK:    w_base = DATA_W'(1) << addr[IDX_W-1:0];
      default:      w_base = addr;
    endcase
    data = pass ? ~w_base : w_base;
  end

endmodule

// File: rtl/sram_pattern_test.sv
// sram_pattern_test: march-style SRAM tester. For each selected pattern it
// writes the whole address space, reads it back and compares, then repeats
// with inverted data. mode=ALL runs ADDR, CHECKER, WALK in turn.
//
// Ports:
//   clk, rst (sync, active-high)   en   - start request (level, re-arm on 0)
//   mode      - pattern select      mem/rw/addr/data2ram - operation strobe
//   ready     - op accept / read data valid    data2fpga - read data
//   busy/done/result - status       err_cnt/fail_addr/fail_exp/fail_act - log
//
// Build option: SRAM_TEST_ERRLOG_EN - mismatches are counted and the first
// one is captured instead of terminating the test; otherwise the log ports
// read as zero and the first mismatch ends the test with result=0.
module sram_pattern_test
  import sram_test_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  output logic                 mem,
  output logic                 rw,
  input  logic                 ready,
  output logic [ADDR_W-1:0]    addr,
  output logic [DATA_W-1:0]    data2ram,
  input  logic [DATA_W-1:0]    data2fpga,
  output logic                 busy,
  output logic                 done,
  output logic                 result,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [ADDR_W-1:0]    fail_addr,
  output logic [DATA_W-1:0]    fail_exp,
  output logic [DATA_W-1:0]    fail_act
);

  state_t            r_state, w_state_nxt;
  mode_t             r_mode, w_mode_nxt;
  mode_t             r_pat, w_pat_nxt;
  logic              r_pass, w_pass_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_result, w_result_nxt;

  logic [DATA_W-1:0] w_addr_lo;
  logic [DATA_W-1:0] w_exp;
  logic              w_at_limit;
  logic              w_match;
  logic              w_cont;
  logic              w_pass_ok;

`ifdef SRAM_TEST_ERRLOG_EN
  logic [ERR_CNT_W-1:0] r_err_cnt, w_err_cnt_nxt;
  logic [ADDR_W-1:0]    r_fail_addr, w_fail_addr_nxt;
  logic [DATA_W-1:0]    r_fail_exp, w_fail_exp_nxt;
  logic [DATA_W-1:0]    r_fail_act, w_fail_act_nxt;
`endif

  assign w_addr_lo  = DATA_W'(r_addr);
  assign w_at_limit = (r_addr == '1);
  assign w_match    = (data2fpga == w_exp);

  sram_pattern_gen #(
    .DATA_W(DATA_W)
  ) u_gen (
    .pattern(r_pat),
    .pass   (r_pass),
    .addr   (w_addr_lo),
    .data   (w_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_mode   <= MODE_ADDR;
      r_pat    <= MODE_ADDR;
      r_pass   <= 1'b0;
      r_addr   <= '0;
      r_result <= 1'b0;
`ifdef SRAM_TEST_ERRLOG_EN
      r_err_cnt   <= '0;
      r_fail_addr <= '0;
      r_fail_exp  <= '0;
      r_fail_act  <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_mode   <= w_mode_nxt;
      r_pat    <= w_pat_nxt;
      r_pass   <= w_pass_nxt;
      r_addr   <= w_addr_nxt;
      r_result <= w_result_nxt;
`ifdef SRAM_TEST_ERRLOG_EN
      r_err_cnt   <= w_err_cnt_nxt;
      r_fail_addr <= w_fail_addr_nxt;
      r_fail_exp  <= w_fail_exp_nxt;
      r_fail_act  <= w_fail_act_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_mode_nxt   = r_mode;
    w_pat_nxt    = r_pat;
    w_pass_nxt   = r_pass;
    w_addr_nxt   = r_addr;
    w_result_nxt = r_result;
    w_cont       = 1'b1;
    w_pass_ok    = 1'b1;
`ifdef SRAM_TEST_ERRLOG_EN
    w_err_cnt_nxt   = r_err_cnt;
    w_fail_addr_nxt = r_fail_addr;
    w_fail_exp_nxt  = r_fail_exp;
    w_fail_act_nxt  = r_fail_act;
`endif

    mem      = 1'b0;
    rw       = 1'b1;
    addr     = '0;
    data2ram = '0;
    busy     = 1'b0;
    done     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_nxt  = ST_WRITE;
          w_mode_nxt   = mode_t'(mode);
          // ALL starts with the ADDR pattern; single modes use themselves
          w_pat_nxt    = (mode_t'(mode) == MODE_ALL) ? MODE_ADDR : mode_t'(mode);
          w_pass_nxt   = 1'b0;
          w_addr_nxt   = '0;
          w_result_nxt = 1'b0;
`ifdef SRAM_TEST_ERRLOG_EN
          w_err_cnt_nxt   = '0;
          w_fail_addr_nxt = '0;
          w_fail_exp_nxt  = '0;
          w_fail_act_nxt  = '0;
`endif
        end
      end

      ST_WRITE: begin
        busy = 1'b1;
        if (ready) begin
          mem      = 1'b1;
          rw       = 1'b0;
          addr     = r_addr;
          data2ram = w_exp;
          if (w_at_limit) begin
            w_addr_nxt  = '0;
            w_state_nxt = ST_READ;
          end else begin
            w_addr_nxt = r_addr + ADDR_W'(1);
          end
        end
      end

      ST_READ: begin
        busy = 1'b1;
        if (ready) begin
          mem         = 1'b1;
          rw          = 1'b1;
          addr        = r_addr;
          w_state_nxt = ST_COMPARE;
        end
      end

      ST_COMPARE: begin
        busy = 1'b1;
        if (ready) begin
`ifdef SRAM_TEST_ERRLOG_EN
          if (!w_match) begin
            if (r_err_cnt != '1) w_err_cnt_nxt = r_err_cnt + ERR_CNT_W'(1);
            if (r_err_cnt == '0) begin
              w_fail_addr_nxt = r_addr;
              w_fail_exp_nxt  = w_exp;
              w_fail_act_nxt  = data2fpga;
            end
          end
          // verdict must include a mismatch found on this very compare
          w_pass_ok = (w_err_cnt_nxt == '0);
`else
          w_cont = w_match;
`endif
          if (!w_cont) begin
            w_result_nxt = 1'b0;
            w_state_nxt  = ST_DONE;
          end else if (!w_at_limit) begin
            w_addr_nxt  = r_addr + ADDR_W'(1);
            w_state_nxt = ST_READ;
          end else if (!r_pass) begin
            w_pass_nxt  = 1'b1;
            w_addr_nxt  = '0;
            w_state_nxt = ST_WRITE;
          end else if (r_mode == MODE_ALL && r_pat != MODE_WALK) begin
            w_pat_nxt   = (r_pat == MODE_ADDR) ? MODE_CHECKER : MODE_WALK;
            w_pass_nxt  = 1'b0;
            w_addr_nxt  = '0;
            w_state_nxt = ST_WRITE;
          end else begin
            w_result_nxt = w_pass_ok;
            w_state_nxt  = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        done = 1'b1;
        if (!en) w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign result = r_result;

`ifdef SRAM_TEST_ERRLOG_EN
  assign err_cnt   = r_err_cnt;
  assign fail_addr = r_fail_addr;
  assign fail_exp  = r_fail_exp;
  assign fail_act  = r_fail_act;
`else
  assign err_cnt   = '0;
  assign fail_addr = '0;
  assign fail_exp  = '0;
  assign fail_act  = '0;
`endif

endmodule

// File: tb/tb_sram_pattern_test.sv
module tb_sram_pattern_test;

  localparam int AW     = 4;
  localparam int DW     = 8;
  localparam int DEPTH  = 16;
  localparam int BUDGET = 4000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          mem, rw;
  logic          ready = 1'b1;
  logic [AW-1:0] addr;
  logic [DW-1:0] data2ram;
  logic [DW-1:0] data2fpga = '0;
  logic          busy, done, result;
  logic [15:0]   err_cnt;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_exp, fail_act;

  sram_pattern_test #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .mem(mem), .rw(rw),
    .ready(ready), .addr(addr), .data2ram(data2ram), .data2fpga(data2fpga),
    .busy(busy), .done(done), .result(result), .err_cnt(err_cnt),
    .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_act(fail_act)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- SRAM model (acts at negedge, away from the DUT edge) ---
  logic [DW-1:0] sram [DEPTH];
  logic [DW-1:0] rd_d;
  bit  st_en = 1'b0;
  int  st_addr = 0;
  int  st_bit = 0;
  bit  rand_ready = 1'b0;
  int  viol = 0;
  int  rd_cnt = 0;
  logic [DW-1:0] wd_q[$];
  int            wa_q[$];

  always @(negedge clk) begin
    if (mem && !ready) viol++;
    if (mem && ready) begin
      if (!rw) begin
        wd_q.push_back(data2ram);
        wa_q.push_back(int'(addr));
        sram[addr] = data2ram;
      end else begin
        rd_cnt++;
        rd_d = sram[addr];
        if (st_en && int'(addr) == st_addr) rd_d[st_bit] = 1'b0;
        data2fpga = rd_d;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- reference model --------------------------------------
  typedef struct {
    bit result;
    int writes;
    int reads;
    int err;
    int faddr;
    int fexp;
    int fact;
  } exp_t;

  logic [DW-1:0] exp_wd[$];
  int            exp_wa[$];

  function automatic logic [DW-1:0] pat_val(input int p, input int ps, input int a);
    logic [DW-1:0] v;
    case (p)
      0:       v = 8'(a);
      1:       v = (a % 2 == 1) ? 8'hAA : 8'h55;
      default: v = 8'(1 << (a % 8));
    endcase
    if (ps == 1) v = ~v;
    return v;
  endfunction

  function automatic exp_t model_expect(input int md, input bit st, input int sa, input int sb);
    exp_t e;
    int pats[$];
    int k = 0;
    int first_k = -1;
    logic [DW-1:0] v;
    e = '{1'b1, 0, 0, 0, 0, 0, 0};
    if (md == 3) pats = '{0, 1, 2};
    else         pats = '{md};
    exp_wd.delete();
    exp_wa.delete();
    foreach (pats[i]) begin
      for (int ps = 0; ps < 2; ps++) begin
        for (int a = 0; a < DEPTH; a++) begin
          exp_wd.push_back(pat_val(pats[i], ps, a));
          exp_wa.push_back(a);
        end
        // a stuck-at-0 bit is only visible where the stored value has it set
        v = pat_val(pats[i], ps, sa);
        if (st && v[sb]) begin
          e.err++;
          if (first_k < 0) begin
            first_k = k;
            e.fexp  = int'(v);
            v[sb]   = 1'b0;
            e.fact  = int'(v);
          end
        end
        k++;
      end
    end
    e.writes = DEPTH * k;
    e.reads  = DEPTH * k;
`ifdef SRAM_TEST_ERRLOG_EN
    e.result = (e.err == 0);
    if (first_k >= 0) e.faddr = sa;
`else
    if (first_k >= 0) begin
      e.result = 1'b0;
      e.writes = DEPTH * (first_k + 1);
      e.reads  = DEPTH * first_k + sa + 1;
    end
    e.err = 0; e.faddr = 0; e.fexp = 0; e.fact = 0;
`endif
    return e;
  endfunction

  // ---------------- run one full test --------------------------------------
  int obs_writes, obs_reads;

  task automatic run_one(input int md, input bit st, input int sa, input int sb, input bit rr);
    exp_t e;
    int cyc;
    int bad;
    e = model_expect(md, st, sa, sb);
    foreach (sram[i]) sram[i] = 8'($urandom);
    wd_q.delete(); wa_q.delete();
    rd_cnt = 0; viol = 0;
    st_en = st; st_addr = sa; st_bit = sb; rand_ready = rr;
    mode = 2'(md);
    en = 1'b1;
    cyc = 0;
    while (!done && cyc < BUDGET) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 7) mode = ~mode;   // must be ignored by the DUT
    end
    chk("done_reached", done, 1'b1);
    obs_writes = wd_q.size();
    obs_reads  = rd_cnt;
    chk("result", result, e.result);
    chk("writes", obs_writes, e.writes);
    chk("reads", obs_reads, e.reads);
    chk("err_cnt", err_cnt, e.err);
    chk("fail_addr", fail_addr, e.faddr);
    chk("fail_exp", fail_exp, e.fexp);
    chk("fail_act", fail_act, e.fact);
    chk("strobe_without_ready", viol, 0);
    bad = 0;
    for (int i = 0; i < wd_q.size() && i < exp_wd.size(); i++) begin
      if (wd_q[i] !== exp_wd[i] || wa_q[i] != exp_wa[i]) begin
        chk($sformatf("wr_data[%0d]", i), wd_q[i], exp_wd[i]);
        chk($sformatf("wr_addr[%0d]", i), wa_q[i], exp_wa[i]);
        bad = 1;
        break;
      end
    end
    if (bad == 0) chk("wr_stream", bad, 0);
    // DONE holds while en stays high
    @(posedge clk); #1;
    chk("done_hold", done, 1'b1);
    chk("result_hold", result, e.result);
    rand_ready = 1'b0;
    en = 1'b0;
    @(posedge clk); #1;
    chk("rearm_done", done, 1'b0);
    chk("rearm_busy", busy, 1'b0);
    st_en = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem"}, mem, 1'b0);
    chk({tag, "_rw"}, rw, 1'b1);
    chk({tag, "_addr"}, addr, '0);
    chk({tag, "_data2ram"}, data2ram, '0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_result"}, result, 1'b0);
    chk({tag, "_err_cnt"}, err_cnt, '0);
    chk({tag, "_fail_addr"}, fail_addr, '0);
    chk({tag, "_fail_exp"}, fail_exp, '0);
    chk({tag, "_fail_act"}, fail_act, '0);
  endtask

  // ---------------- directed vectors ---------------------------------------
  typedef struct {
    int md; bit st; int sa; int sb; bit rr;
    bit exp_result; int exp_writes; int exp_reads;
    int exp_err; int exp_faddr; int exp_fexp; int exp_fact;
  } vec_t;

  vec_t vecs[6];
  logic [DW-1:0] a5_exp[6];
  logic [DW-1:0] a5_got[$];

  initial begin
    vecs[0] = '{0, 1'b0, 0, 0, 1'b0, 1'b1, 32, 32, 0, 0, 0, 0};
    vecs[1] = '{1, 1'b0, 0, 0, 1'b0, 1'b1, 32, 32, 0, 0, 0, 0};
    vecs[2] = '{2, 1'b0, 0, 0, 1'b0, 1'b1, 32, 32, 0, 0, 0, 0};
    vecs[3] = '{3, 1'b0, 0, 0, 1'b0, 1'b1, 96, 96, 0, 0, 0, 0};
`ifdef SRAM_TEST_ERRLOG_EN
    vecs[4] = '{0, 1'b1, 9, 3, 1'b0, 1'b0, 32, 32, 1, 9, 'h09, 'h01};
`else
    vecs[4] = '{0, 1'b1, 9, 3, 1'b0, 1'b0, 16, 10, 0, 0, 0, 0};
`endif
    vecs[5] = '{3, 1'b0, 0, 0, 1'b1, 1'b1, 96, 96, 0, 0, 0, 0};
    a5_exp = '{8'h05, 8'hFA, 8'hAA, 8'h55, 8'h20, 8'hDF};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      run_one(vecs[v].md, vecs[v].st, vecs[v].sa, vecs[v].sb, vecs[v].rr);
      chk($sformatf("vec%0d_result", v), result, vecs[v].exp_result);
      chk($sformatf("vec%0d_writes", v), obs_writes, vecs[v].exp_writes);
      chk($sformatf("vec%0d_reads", v), obs_reads, vecs[v].exp_reads);
      chk($sformatf("vec%0d_err_cnt", v), err_cnt, vecs[v].exp_err);
      chk($sformatf("vec%0d_fail_addr", v), fail_addr, vecs[v].exp_faddr);
      chk($sformatf("vec%0d_fail_exp", v), fail_exp, vecs[v].exp_fexp);
      chk($sformatf("vec%0d_fail_act", v), fail_act, vecs[v].exp_fact);
      if (v == 3) begin
        // six-pass sequence seen at address 5
        a5_got.delete();
        foreach (wa_q[i]) if (wa_q[i] == 5) a5_got.push_back(wd_q[i]);
        chk("addr5_count", a5_got.size(), 6);
        for (int i = 0; i < 6 && i < a5_got.size(); i++)
          chk($sformatf("addr5_write%0d", i), a5_got[i], a5_exp[i]);
      end
    end

    // randomized configurations against the reference model
    for (int r = 0; r < 6; r++) begin
      run_one($urandom_range(0, 3), 1'($urandom_range(0, 1)),
              $urandom_range(0, DEPTH - 1), $urandom_range(0, DW - 1),
              1'($urandom_range(0, 1)));
    end

    // reset while in pass-1 READ, then a clean run
    begin
      int cyc;
      wd_q.delete(); wa_q.delete(); rd_cnt = 0;
      mode = 2'd0;
      en = 1'b1;
      cyc = 0;
      while (!(rd_cnt >= 18 && mem && rw) && cyc < BUDGET) begin
        @(posedge clk); #1;
        cyc++;
      end
      chk("midrst_reached_pass1_read", (rd_cnt >= 18 && mem && rw), 1'b1);
      chk("midrst_writes_before", wd_q.size(), 32);
      rst = 1'b1;
      en  = 1'b0;
      @(posedge clk); #1;
      chk_reset_outputs("midrst");
      rst = 1'b0;
      @(posedge clk); #1;
      chk("midrst_idle_busy", busy, 1'b0);
      run_one(0, 1'b0, 0, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
